// File: rtl/compressed_stream_unpacker.sv
// Splits a compressed byte stream into control-byte groups of literal and copy items
// and hands each item to the decompressor as a one-cycle strobe.
module compressed_stream_unpacker #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             in_byte,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [15:0]            data_in,
  output logic                   control_word_in,
  output logic                   data_in_valid,
  input  logic                   decompressor_busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] item_count
);

  typedef enum logic [2:0] {
    GET_CW, GET_B0, GET_B1, ISSUE, HOLD, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cw_q, cw_d;
  logic [2:0]             idx_q, idx_d;
  logic [15:0]            data_q, data_d;
  logic                   ctrl_q, ctrl_d;
  logic                   last_q, last_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   accept;
  logic                   flag;

  // Outputs are gated by reset so they read as idle even before the first edge in reset.
  assign in_ready        = reset && (state_q == GET_CW || state_q == GET_B0 || state_q == GET_B1);
  assign data_in_valid   = reset && (state_q == HOLD);
  assign done            = reset && (state_q == DONE);
  assign error           = reset && error_q;
  assign data_in         = data_q;
  assign control_word_in = ctrl_q;
  assign item_count      = count_q;

  assign accept = in_valid && in_ready;
  assign flag   = cw_q[3'd7 - idx_q];

  always_comb begin
    state_d = state_q;
    cw_d    = cw_q;
    idx_d   = idx_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    last_d  = last_q;
    error_d = error_q;
    count_d = count_q;
    case (state_q)
      GET_CW: begin
        if (accept) begin
          cw_d    = in_byte;
          idx_d   = 3'd0;
          state_d = in_last ? DONE : GET_B0;
        end
      end
      GET_B0: begin
        if (accept) begin
          last_d = in_last;
          if (!flag) begin
            ctrl_d  = 1'b0;
            data_d  = {8'h00, in_byte};
            state_d = ISSUE;
          end else if (in_last) begin
            // A copy item cut short after its first byte is dropped entirely.
            error_d = 1'b1;
            state_d = DONE;
          end else begin
            ctrl_d  = 1'b1;
            data_d  = {in_byte, 8'h00};
            state_d = GET_B1;
          end
        end
      end
      GET_B1: begin
        if (accept) begin
          data_d  = {data_q[15:8], in_byte};
          last_d  = in_last;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!decompressor_busy) state_d = HOLD;
      end
      HOLD: begin
        count_d = count_q + COUNT_WIDTH'(1);
        if (last_q) begin
          state_d = DONE;
        end else if (idx_q == 3'd7) begin
          idx_d   = 3'd0;
          state_d = GET_CW;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = GET_B0;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = GET_CW;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= GET_CW;
      cw_q    <= 8'h00;
      idx_q   <= 3'd0;
      data_q  <= 16'h0000;
      ctrl_q  <= 1'b0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cw_q    <= cw_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      last_q  <= last_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_compressed_stream_unpacker.sv
// Scoreboard bench: a stream-level reference model queues expected items,
// and a negedge monitor checks every data_in_valid strobe against that queue.
module tb_compressed_stream_unpacker;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] data_in;
  logic        control_word_in;
  logic        data_in_valid;
  logic        decompressor_busy = 1'b0;
  logic        done;
  logic        error;
  logic [15:0] item_count;

  compressed_stream_unpacker #(.COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .data_in(data_in),
    .control_word_in(control_word_in), .data_in_valid(data_in_valid),
    .decompressor_busy(decompressor_busy), .done(done), .error(error),
    .item_count(item_count)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          cycle = 0;
  int          lastPulse = -100;
  int          modelCount = 0;
  logic        busyAtEdge = 1'b0;
  bit          busyRandom = 1'b0;
  logic [16:0] expQ[$];
  logic [7:0]  sBytes[$];
  bit          sLast[$];
  bit          expError;
  int          expItems;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clock) begin
    cycle <= cycle + 1;
    busyAtEdge <= decompressor_busy;
  end

  always @(negedge clock) begin
    if (busyRandom) decompressor_busy = ($urandom_range(0, 2) == 0);
  end

  // Monitor: every strobe must match the oldest expected item, follow a non-busy edge,
  // and be at least two cycles after the previous one.
  always @(negedge clock) begin : monitor
    logic [16:0] e;
    if (reset && data_in_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", {15'd0, control_word_in, data_in}, 32'h1ffff);
      end else begin
        e = expQ.pop_front();
        checkOutput("item", {15'd0, control_word_in, data_in}, {15'd0, e});
      end
      checkOutput("countAtPulse", {16'd0, item_count}, modelCount);
      checkOutput("pulseGap", (cycle - lastPulse >= 2) ? 1 : 0, 1);
      checkOutput("busyAtIssue", {31'd0, busyAtEdge}, 0);
      modelCount++;
      lastPulse = cycle;
    end
  end

  // Reference model: walks the whole stream by the group/item rules.
  task automatic applyModel();
    int n;
    int pos;
    logic [7:0] cw;
    n = sBytes.size();
    pos = 0;
    expError = 1'b0;
    expItems = 0;
    while (pos < n) begin
      cw = sBytes[pos];
      if (sLast[pos]) break;
      pos++;
      for (int k = 0; k < 8 && pos < n; k++) begin
        if (!cw[7-k]) begin
          expQ.push_back({9'h000, sBytes[pos]});
          expItems++;
          if (sLast[pos]) begin pos = n; break; end
          pos++;
        end else begin
          if (sLast[pos] || pos + 1 >= n) begin expError = 1'b1; pos = n; break; end
          expQ.push_back({1'b1, sBytes[pos], sBytes[pos+1]});
          expItems++;
          if (sLast[pos+1]) begin pos = n; break; end
          pos += 2;
        end
      end
    end
  endtask

  task automatic sendByte(logic [7:0] b, bit last);
    int w;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    in_byte = b;
    in_last = last;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 300) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 0, 1);
      in_valid = 1'b0;
      in_last = 1'b0;
      return;
    end
    @(negedge clock);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic applyReset();
    busyRandom = 1'b0;
    decompressor_busy = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rstReady", {31'd0, in_ready}, 0);
    checkOutput("rstData", {16'd0, data_in}, 0);
    checkOutput("rstCtrl", {31'd0, control_word_in}, 0);
    checkOutput("rstValid", {31'd0, data_in_valid}, 0);
    checkOutput("rstDone", {31'd0, done}, 0);
    checkOutput("rstError", {31'd0, error}, 0);
    checkOutput("rstCount", {16'd0, item_count}, 0);
    @(negedge clock);
    @(negedge clock);
    expQ.delete();
    modelCount = 0;
    lastPulse = -100;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("readyAfterReset", {31'd0, in_ready}, 1);
  endtask

  task automatic applyStimulus();
    applyModel();
    for (int i = 0; i < sBytes.size(); i++) sendByte(sBytes[i], sLast[i]);
  endtask

  task automatic finishStream();
    int w;
    w = 0;
    while (!done && w < 400) begin
      @(negedge clock);
      w++;
    end
    busyRandom = 1'b0;
    checkOutput("doneSeen", {31'd0, done}, 1);
    checkOutput("errorFlag", {31'd0, error}, {31'd0, expError});
    checkOutput("finalCount", {16'd0, item_count}, expItems);
    checkOutput("readyInDone", {31'd0, in_ready}, 0);
    checkOutput("queueDrained", expQ.size(), 0);
    repeat (3) @(negedge clock);
    checkOutput("noPulseInDone", {31'd0, data_in_valid}, 0);
  endtask

  task automatic setStream(input logic [7:0] bytes[$]);
    sBytes = bytes;
    sLast.delete();
    foreach (bytes[i]) sLast.push_back(i == bytes.size() - 1);
  endtask

  initial begin : watchdog
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    int w;
    int cut;
    logic [7:0] cw;
    @(negedge clock);

    // Eight literals in one group, then a copy followed by a final literal.
    applyReset();
    setStream('{8'h00, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48});
    applyStimulus();
    finishStream();

    applyReset();
    setStream('{8'h80, 8'h12, 8'h34, 8'h41});
    applyStimulus();
    finishStream();

    // Truncated copy item raises error and issues nothing.
    applyReset();
    setStream('{8'h80, 8'h12});
    applyStimulus();
    finishStream();

    // Long busy while an item waits in ISSUE.
    applyReset();
    setStream('{8'h00, 8'h77});
    applyModel();
    decompressor_busy = 1'b1;
    sendByte(8'h00, 1'b0);
    sendByte(8'h77, 1'b1);
    repeat (20) begin
      checkOutput("busyHoldData", {16'd0, data_in}, 32'h0077);
      checkOutput("busyNoPulse", {31'd0, data_in_valid}, 0);
      @(negedge clock);
    end
    decompressor_busy = 1'b0;
    finishStream();

    // Reset after the third item with a fourth pending, then a fresh stream.
    applyReset();
    expQ.push_back(17'h00001);
    expQ.push_back(17'h00002);
    expQ.push_back(17'h00003);
    sendByte(8'h00, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h03, 1'b0);
    w = 0;
    while (modelCount < 3 && w < 300) begin
      @(negedge clock);
      w++;
    end
    checkOutput("threeIssued", modelCount, 3);
    decompressor_busy = 1'b1;
    sendByte(8'h04, 1'b0);
    repeat (3) @(negedge clock);
    applyReset();
    setStream('{8'h00, 8'h5A});
    applyStimulus();
    finishStream();

    // Random groups cut at a random byte, with random decompressor back-pressure.
    for (int s = 0; s < 25; s++) begin
      applyReset();
      sBytes.delete();
      sLast.delete();
      for (int g = 0; g < $urandom_range(1, 3); g++) begin
        cw = 8'($urandom);
        sBytes.push_back(cw);
        for (int k = 0; k < 8; k++) begin
          sBytes.push_back(8'($urandom));
          if (cw[7-k]) sBytes.push_back(8'($urandom));
        end
      end
      cut = $urandom_range(0, sBytes.size() - 1);
      while (sBytes.size() > cut + 1) void'(sBytes.pop_back());
      foreach (sBytes[i]) sLast.push_back(i == cut);
      busyRandom = 1'b1;
      applyStimulus();
      finishStream();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
